// File: rtl/com_to_between_pkg.sv
// Shared types and CRC helper for the UART-to-parallel board link.
package com_to_between_pkg;

  localparam logic [7:0] Crc8Poly = 8'h07;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitIdle
  } rxStateT;

  typedef enum logic [1:0] {
    TxIdle,
    TxSetup,
    TxReq,
    TxRel
  } txStateT;

  // MSB-first CRC-8, no reflection, no final XOR.
  function automatic logic [7:0] crc8Byte(input logic [7:0] crcIn, input logic [7:0] data);
    logic [7:0] c;
    c = crcIn ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ Crc8Poly) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/com_to_between_if.sv
// Four-phase parallel link to the partner board: byte, request strobe and acknowledge.
interface com_to_between_if;
  logic [7:0] t_data;
  logic       tsent;
  logic       trecieve;

  modport master (output t_data, output tsent, input trecieve);
  modport slave  (input t_data, input tsent, output trecieve);
endinterface

// File: rtl/com_to_between_uart_rx_sampler.sv
// 8N1 UART receiver: rx synchronizer, frame FSM and bit timing.
// byte_valid and frame_err are combinational pulses on the stop-bit sample cycle.
module com_to_between_uart_rx_sampler
  import com_to_between_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic          rxMeta, rxSync;
  rxStateT       stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic [2:0]    bitQ, bitD;
  logic [7:0]    shiftQ, shiftD;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      stateQ <= RxIdle;
      cntQ   <= '0;
      bitQ   <= '0;
      shiftQ <= '0;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      stateQ <= stateD;
      cntQ   <= cntD;
      bitQ   <= bitD;
      shiftQ <= shiftD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    bitD       = bitQ;
    shiftD     = shiftQ;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (stateQ)
      RxIdle: begin
        if (!rxSync && enable) begin
          stateD = RxStart;
          cntD   = '0;
        end
      end
      RxStart: begin
        if (cntQ == HalfLast) begin
          cntD   = '0;
          bitD   = '0;
          stateD = rxSync ? RxIdle : RxData;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      RxData: begin
        if (cntQ == BitLast) begin
          cntD   = '0;
          shiftD = {rxSync, shiftQ[7:1]};
          if (bitQ == 3'd7) stateD = RxStop;
          else              bitD   = bitQ + 1'b1;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      RxStop: begin
        if (cntQ == BitLast) begin
          cntD = '0;
          if (rxSync) begin
            byte_valid = 1'b1;
            stateD     = RxIdle;
          end else begin
            frame_err = 1'b1;
            stateD    = RxWaitIdle;
          end
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      RxWaitIdle: begin
        if (rxSync) stateD = RxIdle;
      end
      default: stateD = RxIdle;
    endcase
  end

  assign byte_data = shiftQ;

endmodule

// File: rtl/com_to_between.sv
// UART bytes in, buffered in a FIFO, forwarded over the four-phase parallel link.
// Keeps a running CRC-8 of every byte the partner has acknowledged.
module com_to_between
  import com_to_between_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    rx,
  com_to_between_if.master        link,
  output logic [7:0]              rx_byte,
  output logic [7:0]              crc,
  output logic                    frame_error,
  output logic                    overflow,
  output logic                    busy,
  output logic                    finish
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic       byteValid, frameErr;
  logic [7:0] byteData;

  com_to_between_uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uart_rx_sampler (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rx        (rx),
    .byte_valid(byteValid),
    .byte_data (byteData),
    .frame_err (frameErr)
  );

  logic [7:0]      fifoMem [DEPTH];
  logic [PtrW-1:0] wrPtrQ, rdPtrQ;
  logic [PtrW:0]   countQ;
  logic            fifoFull, fifoEmpty, doPush, doPop;

  logic            ackMeta, ackSync;
  txStateT         txStateQ, txStateD;
  logic            txDone;
  logic [7:0]      tDataQ, crcQ, rxByteQ;
  logic            finishQ, frameErrorQ, overflowQ;

  assign fifoFull  = (countQ == FullCount);
  assign fifoEmpty = (countQ == '0);
  // A full FIFO drops the byte even if a pop frees a slot on the same edge.
  assign doPush    = byteValid && !fifoFull;

  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtrQ] <= byteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrQ      <= '0;
      rdPtrQ      <= '0;
      countQ      <= '0;
      ackMeta     <= 1'b0;
      ackSync     <= 1'b0;
      txStateQ    <= TxIdle;
      tDataQ      <= '0;
      crcQ        <= '0;
      rxByteQ     <= '0;
      finishQ     <= 1'b0;
      frameErrorQ <= 1'b0;
      overflowQ   <= 1'b0;
    end else begin
      ackMeta  <= link.trecieve;
      ackSync  <= ackMeta;
      txStateQ <= txStateD;
      finishQ  <= txDone;
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop) begin
        rdPtrQ <= rdPtrQ + 1'b1;
        tDataQ <= fifoMem[rdPtrQ];
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
      if (txDone)               crcQ        <= crc8Byte(crcQ, tDataQ);
      if (byteValid)            rxByteQ     <= byteData;
      if (frameErr)             frameErrorQ <= 1'b1;
      if (byteValid && fifoFull) overflowQ  <= 1'b1;
    end
  end

  always_comb begin
    txStateD = txStateQ;
    doPop    = 1'b0;
    txDone   = 1'b0;
    case (txStateQ)
      TxIdle: begin
        if (!fifoEmpty && enable) begin
          txStateD = TxSetup;
          doPop    = 1'b1;
        end
      end
      TxSetup: txStateD = TxReq;
      TxReq: begin
        if (ackSync) txStateD = TxRel;
      end
      TxRel: begin
        if (!ackSync) begin
          txStateD = TxIdle;
          txDone   = 1'b1;
        end
      end
      default: txStateD = TxIdle;
    endcase
  end

  // Decoded straight from the async-reset state so the strobe drops with reset.
  assign link.tsent  = (txStateQ == TxReq);
  assign link.t_data = tDataQ;
  assign rx_byte     = rxByteQ;
  assign crc         = crcQ;
  assign frame_error = frameErrorQ;
  assign overflow    = overflowQ;
  assign finish      = finishQ;
  assign busy        = !fifoEmpty || (txStateQ != TxIdle);

endmodule

// File: tb/tb_com_to_between.sv
// Directed bench: UART frames in, responder model on the link, scoreboard on finish.
module tb_com_to_between;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_byte, crc;
  logic       frame_error, overflow, busy, finish;

  com_to_between_if link ();

  com_to_between #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rx         (rx),
    .link       (link),
    .rx_byte    (rx_byte),
    .crc        (crc),
    .frame_error(frame_error),
    .overflow   (overflow),
    .busy       (busy),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         finishCnt = 0;
  logic [7:0] expQ[$];
  logic [7:0] modelCrc = 8'h00;
  logic [7:0] expByte;
  bit         ackEnable = 1'b1;
  int         rState = 0;
  int         rCnt = 0;

  // Bitwise feedback form of the 0x07 CRC, one message bit per step.
  function automatic logic [7:0] crcModel(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy || link.trecieve) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s: drain timeout, %0d bytes still expected", name, expQ.size());
    end
  endtask

  // Partner receiver: acks 5 cycles after tsent, releases 2 cycles after tsent drops.
  always @(negedge clk) begin
    if (reset) begin
      rState = 0;
      link.trecieve = 1'b0;
    end else begin
      case (rState)
        0: if (link.tsent && ackEnable) begin
          rCnt = 0;
          rState = 1;
        end
        1: begin
          rCnt = rCnt + 1;
          if (rCnt == 5) begin
            link.trecieve = 1'b1;
            rState = 2;
          end
        end
        2: if (!link.tsent) begin
          rCnt = 0;
          rState = 3;
        end
        default: begin
          rCnt = rCnt + 1;
          if (rCnt == 2) begin
            link.trecieve = 1'b0;
            rState = 0;
          end
        end
      endcase
    end
  end

  // Scoreboard monitor: every finish pulse must match the next expected byte and CRC.
  always @(negedge clk) begin
    if (reset) begin
      modelCrc = 8'h00;
    end else if (finish) begin
      finishCnt++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_finish: t_data %02h delivered with nothing expected",
                 link.t_data);
      end else begin
        expByte  = expQ.pop_front();
        modelCrc = crcModel(modelCrc, expByte);
        check("t_data", link.t_data, expByte);
        check("crc", crc, modelCrc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fc0;
    int  n;
    bit  sawTsent;
    repeat (3) @(negedge clk);
    check("rst_t_data", link.t_data, 8'h00);
    check("rst_tsent", link.tsent, 1'b0);
    check("rst_crc", crc, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte
    fc0 = finishCnt;
    expQ.push_back(8'hA5);
    sendFrame(8'hA5, 1'b1);
    waitDrain("single");
    repeat (3) @(negedge clk);
    check("single_rx_byte", rx_byte, 8'hA5);
    check("single_t_data", link.t_data, 8'hA5);
    check("single_crc", crc, 8'h72);
    check("single_finish_count", 8'(finishCnt - fc0), 8'd1);
    check("single_frame_error", frame_error, 1'b0);
    check("single_overflow", overflow, 1'b0);

    // Glitch: short low pulse must not start a frame
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    check("glitch_frame_error", frame_error, 1'b0);
    check("glitch_overflow", overflow, 1'b0);
    check("glitch_rx_byte", rx_byte, 8'hA5);

    // Enable gating
    enable = 1'b0;
    sendFrame(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    check("gate_busy", busy, 1'b0);
    check("gate_rx_byte", rx_byte, 8'hA5);
    check("gate_t_data", link.t_data, 8'hA5);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    expQ.push_back(8'h43);
    sendFrame(8'h43, 1'b1);
    waitDrain("gate_resume");
    check("gate_resume_rx_byte", rx_byte, 8'h43);
    check("gate_resume_t_data", link.t_data, 8'h43);

    // Framing error then a good byte
    sendFrame(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_flag", frame_error, 1'b1);
    check("ferr_tsent", link.tsent, 1'b0);
    check("ferr_busy", busy, 1'b0);
    check("ferr_rx_byte", rx_byte, 8'h43);
    expQ.push_back(8'h11);
    sendFrame(8'h11, 1'b1);
    waitDrain("ferr_next");
    check("ferr_next_rx_byte", rx_byte, 8'h11);

    // Overflow: responder stalled, six frames into one in flight plus four slots
    ackEnable = 1'b0;
    fc0 = finishCnt;
    for (int i = 1; i <= 6; i++) begin
      sendFrame(8'(i), 1'b1);
      if (i <= 5) expQ.push_back(8'(i));
    end
    repeat (5) @(negedge clk);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_tsent", link.tsent, 1'b1);
    check("ovf_t_data", link.t_data, 8'h01);
    check("ovf_busy", busy, 1'b1);
    check("ovf_no_finish", 8'(finishCnt - fc0), 8'd0);
    ackEnable = 1'b1;
    waitDrain("ovf_drain");
    check("ovf_finish_count", 8'(finishCnt - fc0), 8'd5);

    // Reset during REQ
    ackEnable = 1'b0;
    sendFrame(8'h77, 1'b1);
    n = 0;
    while (!link.tsent && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_tsent_high", link.tsent, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_tsent", link.tsent, 1'b0);
    check("mid_rst_crc", crc, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ackEnable = 1'b1;
    fc0 = finishCnt;
    sawTsent = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (link.tsent) sawTsent = 1'b1;
    end
    check("post_rst_no_tsent", sawTsent, 1'b0);
    check("post_rst_no_finish", 8'(finishCnt - fc0), 8'd0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_overflow", overflow, 1'b0);
    check("post_rst_frame_error", frame_error, 1'b0);
    check("post_rst_rx_byte", rx_byte, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
